// File: rtl/merge_arb.sv
// merge_arb: round-robin arbiter sharing one 4-phase bundled-data output
// channel between two asynchronous 4-phase requesters.
module merge_arb #(
    parameter int unsigned N    = 1,
    parameter int unsigned SYNC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_i,
    output logic         a_i,
    input  logic [N-1:0] d_i,
    input  logic         r1_i,
    output logic         a1_i,
    input  logic [N-1:0] d1_i,
    output logic         r_o,
    input  logic         a_o,
    output logic [N-1:0] d_o,
    output logic [1:0]   gnt
);

    typedef enum logic [1:0] {IDLE, FWD, ACKD, RTZ} state_t;

    state_t          state;
    logic [SYNC-1:0] sync0;
    logic [SYNC-1:0] sync1;
    logic [SYNC-1:0] synca;
    logic            rs0;
    logic            rs1;
    logic            as_q;
    logic            hold;
    logic            last;
    logic            win;
    logic            win_req;

    assign rs0  = sync0[SYNC-1];
    assign rs1  = sync1[SYNC-1];
    assign as_q = synca[SYNC-1];

    // Freeze all state for the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= 1'b1;
        end else begin
            hold <= 1'b0;
        end
    end

    // Multi-flop synchronizers for the asynchronous request/ack inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= '0;
            sync1 <= '0;
            synca <= '0;
        end else if (!hold) begin
            sync0 <= {sync0[SYNC-2:0], r_i};
            sync1 <= {sync1[SYNC-2:0], r1_i};
            synca <= {synca[SYNC-2:0], a_o};
        end
    end

    // Winner is the sole requester, or on a tie the channel that did not win last;
    // win_req is the synchronized request of the current owner (held in last)
    always_comb begin
        win = rs1;
        if (rs0 && rs1) begin
            win = ~last;
        end
        win_req = last ? rs1 : rs0;
    end

    // Handshake sequencer: grant, forward ack, return-to-zero, release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            r_o   <= 1'b0;
            a_i   <= 1'b0;
            a1_i  <= 1'b0;
            d_o   <= '0;
            gnt   <= 2'b00;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (rs0 || rs1) begin
                        d_o   <= win ? d1_i : d_i;
                        gnt   <= win ? 2'b10 : 2'b01;
                        last  <= win;
                        r_o   <= 1'b1;
                        state <= FWD;
                    end
                end
                FWD: begin
                    if (as_q) begin
                        if (last) begin
                            a1_i <= 1'b1;
                        end else begin
                            a_i <= 1'b1;
                        end
                        state <= ACKD;
                    end
                end
                ACKD: begin
                    if (!win_req) begin
                        r_o   <= 1'b0;
                        state <= RTZ;
                    end
                end
                RTZ: begin
                    if (!as_q) begin
                        a_i   <= 1'b0;
                        a1_i  <= 1'b0;
                        gnt   <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
